// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential restoring divider. Divides a 2N-bit unsigned
//             dividend by an N-bit unsigned divisor, one quotient bit per
//             clock, MSB first. Produces an N-bit quotient (low bits of the
//             full quotient), an N-bit remainder, an overflow flag and a
//             divide-by-zero flag.
//  Ports    : clk        - clock, rising edge active
//             rst        - synchronous active-high reset
//             start      - request pulse, samples dividend/divisor
//             dividend   - 2N-bit unsigned dividend
//             divisor    - N-bit unsigned divisor
//             busy       - high while an operation is running
//             done       - one-cycle pulse when results are valid
//             quotient   - registered quotient (low N bits)
//             remainder  - registered remainder
//             ovf        - full quotient does not fit in N bits
//             dz         - division by zero
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             ovf,
    output logic             dz
);

    localparam int                 c_cnt_w = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [2*N-1:0]       dvd_q,       dvd_d;
    logic [N-1:0]         dvs_q,       dvs_d;
    logic [N-1:0]         rem_q,       rem_d;
    // Only 2N-1 quotient bits need storing: the final bit is shifted in
    // combinationally on the last step and goes straight to the outputs.
    logic [2*N-2:0]       quo_q,       quo_d;
    logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
    logic [N-1:0]         quotient_q,  quotient_d;
    logic [N-1:0]         remainder_q, remainder_d;
    logic                 ovf_q,       ovf_d;
    logic                 dz_q,        dz_d;

    // One restoring step. The partial remainder before the shift is always
    // below the divisor, so N bits hold it; after the shift it needs N+1 bits
    // and the compare/subtract is done at that width so no carry is lost.
    logic [c_cnt_w-1:0]   w_idx;
    logic [N:0]           w_rem_sh;
    logic [N:0]           w_diff;
    logic                 w_ge;
    logic [N-1:0]         w_rem_next;
    logic [2*N-1:0]       w_quo_next;
    logic                 w_unused_diff_msb;

    assign w_idx             = c_last - cnt_q;
    assign w_rem_sh          = {rem_q, dvd_q[w_idx]};
    assign w_diff            = w_rem_sh - {1'b0, dvs_q};
    assign w_ge              = (w_rem_sh >= {1'b0, dvs_q});
    assign w_rem_next        = w_ge ? w_diff[N-1:0] : w_rem_sh[N-1:0];
    assign w_quo_next        = {quo_q, w_ge};
    // The difference is below the divisor whenever it is selected, so its MSB
    // carries no information.
    assign w_unused_diff_msb = w_diff[N];

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = '0;
                    if (divisor == '0) begin
                        // Divide by zero short-circuits straight to DONE.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[N-1:0];
                        ovf_d       = 1'b0;
                        dz_d        = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = w_rem_next;
                quo_d = w_quo_next[2*N-2:0];
                cnt_d = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last) begin
                    state_d     = DONE;
                    quotient_d  = w_quo_next[N-1:0];
                    remainder_d = w_rem_next;
                    ovf_d       = |w_quo_next[2*N-1:N];
                    dz_d        = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Directed self-checking testbench for seq_divider (N = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           ovf;
    logic           dz;

    int vecs  = 0;
    int fails = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; sample/drive 1 time unit afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        rst = 1'b0;
        vecs++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vecs++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        vecs++; if (quotient !== 4'd0)  begin fails++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
        vecs++; if (remainder !== 4'd0) begin fails++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
        vecs++; if (ovf !== 1'b0)       begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        vecs++; if (dz !== 1'b0)        begin fails++; $display("FAIL reset_dz got=%b exp=0", dz); end
    endtask

    // 143/11: busy exactly 8 cycles, then a single done cycle.
    task automatic test_basic();
        dividend = 8'd143; divisor = 4'd11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vecs++; if (busy !== 1'b1 || done !== 1'b0) begin
                fails++; $display("FAIL basic_run_cycle%0d busy=%b done=%b exp busy=1 done=0", i, busy, done);
            end
            tick();
        end
        vecs++; if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_done done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        vecs++; if (quotient !== 4'd13 || remainder !== 4'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
            fails++; $display("FAIL basic_result q=%0d r=%0d ovf=%b dz=%b exp q=13 r=0 ovf=0 dz=0", quotient, remainder, ovf, dz);
        end
        tick();
        vecs++; if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_after done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    // Runs several operations back to back (with idle gaps), checking results
    // and that outputs hold while idle.
    task automatic test_normal();
        logic [7:0] a_dvd [6] = '{8'd225, 8'd0, 8'd200, 8'd239, 8'd254, 8'd255};
        logic [3:0] a_dvs [6] = '{4'd15,  4'd7, 4'd3,   4'd15,  4'd15,  4'd1};
        logic [3:0] a_q   [6] = '{4'd15,  4'd0, 4'd2,   4'd15,  4'd0,   4'd15};
        logic [3:0] a_r   [6] = '{4'd0,   4'd0, 4'd2,   4'd14,  4'd14,  4'd0};
        logic       a_o   [6] = '{1'b0,   1'b0, 1'b1,   1'b0,   1'b1,   1'b1};
        for (int t = 0; t < 6; t++) begin
            dividend = a_dvd[t]; divisor = a_dvs[t]; start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            vecs++; if (done !== 1'b1) begin
                fails++; $display("FAIL normal%0d_done got=%b exp=1", t, done);
            end
            vecs++; if (quotient !== a_q[t] || remainder !== a_r[t] || ovf !== a_o[t] || dz !== 1'b0) begin
                fails++; $display("FAIL normal%0d_result %0d/%0d q=%0d r=%0d ovf=%b dz=%b exp q=%0d r=%0d ovf=%b dz=0",
                                  t, a_dvd[t], a_dvs[t], quotient, remainder, ovf, dz, a_q[t], a_r[t], a_o[t]);
            end
            dividend = 8'hFF; divisor = 4'd0;
            tick(); tick(); tick();
            vecs++; if (quotient !== a_q[t] || remainder !== a_r[t] || ovf !== a_o[t] || done !== 1'b0) begin
                fails++; $display("FAIL normal%0d_hold q=%0d r=%0d ovf=%b done=%b exp q=%0d r=%0d ovf=%b done=0",
                                  t, quotient, remainder, ovf, done, a_q[t], a_r[t], a_o[t]);
            end
        end
    endtask

    // 0x5A/0: done on the cycle right after the start edge, busy never high.
    task automatic test_div_zero();
        dividend = 8'h5A; divisor = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        vecs++; if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL dz_done done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        vecs++; if (dz !== 1'b1 || ovf !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd10) begin
            fails++; $display("FAIL dz_result dz=%b ovf=%b q=%0d r=%0d exp dz=1 ovf=0 q=15 r=10", dz, ovf, quotient, remainder);
        end
        tick();
        vecs++; if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL dz_after done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    // start held high: 143/11 then 100/9 loaded in the DONE cycle.
    task automatic test_back_to_back();
        dividend = 8'd143; divisor = 4'd11; start = 1'b1;
        tick();
        // Operands change while RUN with start still high: must be ignored.
        dividend = 8'd100; divisor = 4'd9;
        for (int i = 0; i < 8; i++) begin
            vecs++; if (busy !== 1'b1) begin
                fails++; $display("FAIL b2b_run1_cycle%0d busy=%b exp=1", i, busy);
            end
            tick();
        end
        vecs++; if (done !== 1'b1 || quotient !== 4'd13 || remainder !== 4'd0 || ovf !== 1'b0) begin
            fails++; $display("FAIL b2b_first done=%b q=%0d r=%0d ovf=%b exp done=1 q=13 r=0 ovf=0", done, quotient, remainder, ovf);
        end
        tick();
        start = 1'b0;
        vecs++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_restart busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        for (int i = 0; i < 8; i++) tick();
        vecs++; if (done !== 1'b1 || quotient !== 4'd11 || remainder !== 4'd1 || ovf !== 1'b0 || dz !== 1'b0) begin
            fails++; $display("FAIL b2b_second done=%b q=%0d r=%0d ovf=%b dz=%b exp done=1 q=11 r=1 ovf=0 dz=0",
                              done, quotient, remainder, ovf, dz);
        end
        tick();
    endtask

    // Reset during RUN cycle 4 aborts; reset beats start; then a clean op.
    task automatic test_reset_mid_run();
        int seen_done;
        dividend = 8'd143; divisor = 4'd11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs busy=%b done=%b q=%0d r=%0d ovf=%b dz=%b exp all 0",
                              busy, done, quotient, remainder, ovf, dz);
        end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
            tick();
        end
        vecs++; if (seen_done !== 0) begin
            fails++; $display("FAIL midrst_no_done active_cycles=%0d exp=0", seen_done);
        end
        // rst and start at the same edge: reset wins.
        dividend = 8'h5A; divisor = 4'd0; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        vecs++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
            fails++; $display("FAIL rst_priority busy=%b done=%b dz=%b exp 0 0 0", busy, done, dz);
        end
        dividend = 8'd100; divisor = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        vecs++; if (done !== 1'b1 || quotient !== 4'd11 || remainder !== 4'd1 || ovf !== 1'b0) begin
            fails++; $display("FAIL midrst_recover done=%b q=%0d r=%0d ovf=%b exp done=1 q=11 r=1 ovf=0",
                              done, quotient, remainder, ovf);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_normal();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
`default_nettype wire
